uart_packet_tx: RTL and testbench

UART_PACKET_TX -- requirements
Module: uart_packet_tx

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_frame_ser.sv | 64 ++++++
 rtl/uart_packet_tx.sv | 167 ++++++++++++++++
 tb/tb_uart_packet_tx.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the packet UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE,
    PAR_EVEN,
    PAR_ODD
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    GAP
  } tx_state_t;

  // Phase timer and frame counter are sized for the largest legal values:
  // 9 data bits, 15 gap bits, 13-bit frames.
  localparam int TIMER_W = 4;
  localparam int FLEN_W  = 4;

  // Bit times in one frame: start + data + optional parity + stop bits.
  function automatic logic [FLEN_W-1:0] frame_len(input int         data_bits,
                                                  input logic       has_parity,
                                                  input logic [1:0] stop_bits);
    return FLEN_W'(data_bits + 1) + {3'b000, has_parity} + {2'b00, stop_bits};
  endfunction

endpackage

// File: rtl/uart_frame_ser.sv
// Single-frame serializer: shifts start, data (LSB first), optional parity
// and stop bits onto a registered line that idles high between frames.
module uart_frame_ser
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8
) (
  input  logic                 clk_baud,
  input  logic                 rst,
  input  logic                 load,
  input  logic [DATA_BITS-1:0] data,
  input  parity_mode_t         parity_mode,
  input  logic [1:0]           stop_count,
  output logic                 bit_out,
  output logic                 frame_done
);

  // Frame image is wide enough for two stop bits; any slot past the real
  // frame length is 1, so shorter stop/parity settings just end earlier.
  localparam int FW = DATA_BITS + 4;

  logic [FW-1:0]     frame;
  logic [FW-1:0]     shreg_q;
  logic [FLEN_W-1:0] len;
  logic [FLEN_W-1:0] cnt_q;
  logic              active_q;
  logic              bit_q;
  logic              par_bit;

  // Build the frame image and its length from the current load data.
  always_comb begin
    par_bit = (^data) ^ (parity_mode == PAR_ODD);
    frame   = {2'b11, (parity_mode == PAR_NONE) ? 1'b1 : par_bit, data, 1'b0};
    len     = frame_len(DATA_BITS, parity_mode != PAR_NONE, stop_count);
  end

  // Shift the frame out one bit per cycle; cnt_q counts remaining bit times.
  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      bit_q    <= 1'b1;
      shreg_q  <= '1;
      cnt_q    <= '0;
      active_q <= 1'b0;
    end else if (load) begin
      bit_q    <= frame[0];
      shreg_q  <= {1'b1, frame[FW-1:1]};
      cnt_q    <= len - FLEN_W'(1);
      active_q <= 1'b1;
    end else if (active_q) begin
      if (cnt_q == '0) begin
        active_q <= 1'b0;
        bit_q    <= 1'b1;
      end else begin
        bit_q   <= shreg_q[0];
        shreg_q <= {1'b1, shreg_q[FW-1:1]};
        cnt_q   <= cnt_q - FLEN_W'(1);
      end
    end
  end

  assign bit_out    = bit_q;
  assign frame_done = active_q && (cnt_q == '0);

endmodule

// File: rtl/uart_packet_tx.sv
// Packet UART transmitter: captures a multi-byte packet and sends it as a
// sequence of frames with optional inter-frame gaps, abort and done pulse.
//
// state  | meaning
// IDLE   | line high, waiting for ready
// START  | start bit on the line
// DATA   | data bits on the line, LSB first
// PARITY | parity bit on the line
// STOP   | stop bit(s) on the line; decides next frame, gap or finish
// GAP    | idle-high spacing between frames of one packet
module uart_packet_tx
  import uart_pkg::*;
#(
  parameter  int           PACKET_WIDTH = 4,
  parameter  int           DATA_BITS    = 8,
  parameter  parity_mode_t PARITY_MODE  = PAR_EVEN,
  parameter  int           STOP_BITS    = 1,
  parameter  int           GAP_BITS     = 0,
  localparam int           IDX_W        = $clog2(PACKET_WIDTH) + 1
) (
  input  logic                              clk_baud,
  input  logic                              rst,
  input  logic [PACKET_WIDTH*DATA_BITS-1:0] sys_packet,
  input  logic                              ready,
  input  logic                              abort,
  output logic                              uart_stream,
  output logic                              busy,
  output logic                              done,
  output logic [IDX_W-1:0]                  byte_index
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_WIDTH - 1);

  tx_state_t                         state_q, state_d;
  logic [TIMER_W-1:0]                timer_q, timer_val;
  logic                              timer_load;
  logic                              accept, load_next, finish, finish_done;
  logic                              abort_q, abort_hit, last_byte;
  logic                              busy_q, done_q;
  logic [IDX_W-1:0]                  idx_q;
  // Holds the bytes still waiting to be sent, next one in the low bits.
  logic [PACKET_WIDTH*DATA_BITS-1:0] shadow_q;
  logic                              ser_load, ser_frame_done, ser_bit;
  logic [DATA_BITS-1:0]              ser_data;

  assign last_byte = (idx_q == LAST_IDX);
  // An abort arriving on the final stop edge still counts for this frame.
  assign abort_hit = abort_q | abort;

  // State register.
  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and sequencing strobes.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    load_next   = 1'b0;
    finish      = 1'b0;
    finish_done = 1'b0;
    timer_load  = 1'b0;
    timer_val   = '0;
    case (state_q)
      IDLE: begin
        if (ready) begin
          accept  = 1'b1;
          state_d = START;
        end
      end
      START: begin
        state_d    = DATA;
        timer_load = 1'b1;
        timer_val  = TIMER_W'(DATA_BITS - 1);
      end
      DATA: begin
        if (timer_q == '0) begin
          if (PARITY_MODE == PAR_NONE) state_d = STOP;
          else                         state_d = PARITY;
        end
      end
      PARITY: state_d = STOP;
      STOP: begin
        if (ser_frame_done) begin
          if (abort_hit || last_byte) begin
            state_d     = IDLE;
            finish      = 1'b1;
            finish_done = !abort_hit;
          end else if (GAP_BITS > 0) begin
            state_d    = GAP;
            timer_load = 1'b1;
            timer_val  = TIMER_W'(GAP_BITS - 1);
          end else begin
            state_d   = START;
            load_next = 1'b1;
          end
        end
      end
      GAP: begin
        if (timer_q == '0) begin
          state_d   = START;
          load_next = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Phase down-counter for DATA and GAP; terminal count is zero.
  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst)                  timer_q <= '0;
    else if (timer_load)      timer_q <= timer_val;
    else if (timer_q != '0)   timer_q <= timer_q - TIMER_W'(1);
  end

  // Packet bookkeeping: shadow copy, byte index, busy/done, abort latch.
  always_ff @(posedge clk_baud or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
      abort_q  <= 1'b0;
    end else begin
      done_q <= finish_done;
      if (accept) begin
        shadow_q <= sys_packet >> DATA_BITS;
        busy_q   <= 1'b1;
        idx_q    <= '0;
        abort_q  <= 1'b0;
      end else if (load_next) begin
        shadow_q <= shadow_q >> DATA_BITS;
        idx_q    <= idx_q + IDX_W'(1);
      end
      if (finish) begin
        busy_q  <= 1'b0;
        idx_q   <= '0;
        abort_q <= 1'b0;
      end else if (busy_q && abort) begin
        abort_q <= 1'b1;
      end
    end
  end

  assign ser_load = accept | load_next;
  assign ser_data = accept ? sys_packet[DATA_BITS-1:0] : shadow_q[DATA_BITS-1:0];

  uart_frame_ser #(
    .DATA_BITS (DATA_BITS)
  ) u_ser (
    .clk_baud    (clk_baud),
    .rst         (rst),
    .load        (ser_load),
    .data        (ser_data),
    .parity_mode (PARITY_MODE),
    .stop_count  (2'(STOP_BITS)),
    .bit_out     (ser_bit),
    .frame_done  (ser_frame_done)
  );

  assign uart_stream = ser_bit;
  assign busy        = busy_q;
  assign done        = done_q;
  assign byte_index  = idx_q;

endmodule

// File: tb/tb_uart_packet_tx.sv
// Directed bench for uart_packet_tx: three parameterisations side by side.
module tb_uart_packet_tx;
  import uart_pkg::*;

  logic clk_baud = 1'b0;
  always #5 clk_baud = ~clk_baud;

  int n_check = 0;
  int n_pass  = 0;

  // Instance A: defaults (4 bytes, 8 data bits, even parity, 1 stop, no gap)
  logic        a_rst, a_ready, a_abort, a_line, a_busy, a_done;
  logic [31:0] a_pkt;
  logic [2:0]  a_idx;
  uart_packet_tx dut_a (
    .clk_baud(clk_baud), .rst(a_rst), .sys_packet(a_pkt), .ready(a_ready),
    .abort(a_abort), .uart_stream(a_line), .busy(a_busy), .done(a_done),
    .byte_index(a_idx));

  // Instance B: single byte, odd parity
  logic        b_rst, b_ready, b_abort, b_line, b_busy, b_done;
  logic [7:0]  b_pkt;
  logic [0:0]  b_idx;
  uart_packet_tx #(.PACKET_WIDTH(1), .PARITY_MODE(PAR_ODD)) dut_b (
    .clk_baud(clk_baud), .rst(b_rst), .sys_packet(b_pkt), .ready(b_ready),
    .abort(b_abort), .uart_stream(b_line), .busy(b_busy), .done(b_done),
    .byte_index(b_idx));

  // Instance C: two bytes, two stop bits, three gap bits
  logic        c_rst, c_ready, c_abort, c_line, c_busy, c_done;
  logic [15:0] c_pkt;
  logic [1:0]  c_idx;
  uart_packet_tx #(.PACKET_WIDTH(2), .STOP_BITS(2), .GAP_BITS(3)) dut_c (
    .clk_baud(clk_baud), .rst(c_rst), .sys_packet(c_pkt), .ready(c_ready),
    .abort(c_abort), .uart_stream(c_line), .busy(c_busy), .done(c_done),
    .byte_index(c_idx));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_check++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Expected line level at bit position pos of an 8-bit frame with parity.
  function automatic logic frame_bit(input logic [7:0] b, input int pos, input bit odd);
    if (pos == 0) return 1'b0;
    if (pos <= 8) return b[pos-1];
    if (pos == 9) return (^b) ^ odd;
    return 1'b1;
  endfunction

  // Called at the negedge inside the start bit of byte 0; ends at the done cycle.
  task automatic check_a_packet(input string tag, input logic [31:0] pkt);
    logic [7:0] b;
    for (int k = 0; k < 44; k++) begin
      if (k > 0) @(negedge clk_baud);
      b = pkt[(k/11)*8 +: 8];
      chk($sformatf("%s line c%0d", tag, k), 32'(a_line), 32'(frame_bit(b, k % 11, 1'b0)));
      chk($sformatf("%s idx c%0d", tag, k), 32'(a_idx), 32'(k / 11));
      if (k % 11 == 5) chk($sformatf("%s busy c%0d", tag, k), 32'(a_busy), 32'd1);
      if (k % 11 == 10) chk($sformatf("%s nodone c%0d", tag, k), 32'(a_done), 32'd0);
    end
    @(negedge clk_baud);
    chk({tag, " done"}, 32'(a_done), 32'd1);
    chk({tag, " busy end"}, 32'(a_busy), 32'd0);
    chk({tag, " line end"}, 32'(a_line), 32'd1);
    chk({tag, " idx end"}, 32'(a_idx), 32'd0);
  endtask

  logic [10:0] b_exp;

  initial begin
    a_rst = 1'b1; a_ready = 1'b0; a_abort = 1'b0; a_pkt = '0;
    b_rst = 1'b1; b_ready = 1'b0; b_abort = 1'b0; b_pkt = '0;
    c_rst = 1'b1; c_ready = 1'b0; c_abort = 1'b0; c_pkt = '0;

    // Reset state
    @(negedge clk_baud);
    chk("rst a line", 32'(a_line), 32'd1);
    chk("rst a busy", 32'(a_busy), 32'd0);
    chk("rst a done", 32'(a_done), 32'd0);
    chk("rst a idx",  32'(a_idx),  32'd0);
    chk("rst b line", 32'(b_line), 32'd1);
    chk("rst c line", 32'(c_line), 32'd1);
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    @(negedge clk_baud);
    chk("idle a line", 32'(a_line), 32'd1);

    // Default packet, one-cycle ready pulse
    a_pkt = 32'h44_33_22_11; a_ready = 1'b1;
    @(negedge clk_baud);
    a_ready = 1'b0;
    check_a_packet("basic", 32'h44_33_22_11);
    @(negedge clk_baud);
    chk("basic done pulse width", 32'(a_done), 32'd0);

    // Single byte odd parity: 0,1,1,1,0,0,0,0,0,0,1 (bit k of b_exp)
    b_exp = 11'b10000001110;
    b_pkt = 8'h07; b_ready = 1'b1;
    @(negedge clk_baud);
    b_ready = 1'b0;
    b_pkt = 8'hFF;
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk_baud);
      chk($sformatf("odd line c%0d", k), 32'(b_line), 32'(b_exp[k]));
      chk($sformatf("odd busy c%0d", k), 32'(b_busy), 32'd1);
    end
    @(negedge clk_baud);
    chk("odd busy end", 32'(b_busy), 32'd0);
    chk("odd done", 32'(b_done), 32'd1);
    chk("odd idx", 32'(b_idx), 32'd0);

    // Two bytes, two stop bits, three gap bits: 27 cycles
    c_pkt = 16'h81_3C; c_ready = 1'b1;
    @(negedge clk_baud);
    c_ready = 1'b0;
    for (int k = 0; k < 27; k++) begin
      if (k > 0) @(negedge clk_baud);
      if (k < 12)
        chk($sformatf("gap line c%0d", k), 32'(c_line), 32'(frame_bit(8'h3C, k, 1'b0)));
      else if (k < 15)
        chk($sformatf("gap line c%0d", k), 32'(c_line), 32'd1);
      else
        chk($sformatf("gap line c%0d", k), 32'(c_line), 32'(frame_bit(8'h81, k - 15, 1'b0)));
      chk($sformatf("gap idx c%0d", k), 32'(c_idx), (k < 15) ? 32'd0 : 32'd1);
      chk($sformatf("gap done c%0d", k), 32'(c_done), 32'd0);
    end
    @(negedge clk_baud);
    chk("gap done", 32'(c_done), 32'd1);
    chk("gap busy end", 32'(c_busy), 32'd0);
    @(negedge clk_baud);
    chk("gap done clear", 32'(c_done), 32'd0);

    // Ready held high: back-to-back packets; packet input changes mid-flight
    @(negedge clk_baud);
    a_pkt = 32'hA5_5A_F0_0F; a_ready = 1'b1;
    @(negedge clk_baud);
    a_pkt = 32'h12_34_56_78;
    check_a_packet("held1", 32'hA5_5A_F0_0F);
    @(negedge clk_baud);
    a_ready = 1'b0;
    check_a_packet("held2", 32'h12_34_56_78);
    @(negedge clk_baud);
    chk("held idle busy", 32'(a_busy), 32'd0);
    chk("held idle done", 32'(a_done), 32'd0);
    chk("held idle line", 32'(a_line), 32'd1);

    // Abort during data bit 3 of byte 1
    @(negedge clk_baud);
    a_pkt = 32'h5A_C3_96_0F; a_ready = 1'b1;
    @(negedge clk_baud);
    a_ready = 1'b0;
    for (int k = 0; k < 22; k++) begin
      if (k > 0) @(negedge clk_baud);
      if (k == 15) a_abort = 1'b1;
      if (k == 16) a_abort = 1'b0;
      chk($sformatf("abort line c%0d", k), 32'(a_line),
          32'(frame_bit(k < 11 ? 8'h0F : 8'h96, k % 11, 1'b0)));
      chk($sformatf("abort idx c%0d", k), 32'(a_idx), 32'(k / 11));
    end
    for (int k = 22; k < 32; k++) begin
      @(negedge clk_baud);
      chk($sformatf("abort quiet line c%0d", k), 32'(a_line), 32'd1);
      chk($sformatf("abort quiet busy c%0d", k), 32'(a_busy), 32'd0);
      chk($sformatf("abort quiet done c%0d", k), 32'(a_done), 32'd0);
    end

    // Reset mid-data, then re-request with abort also high in IDLE
    a_pkt = 32'hDE_AD_E0_E0; a_ready = 1'b1;
    @(negedge clk_baud);
    a_ready = 1'b0;
    repeat (15) @(negedge clk_baud);
    chk("pre-rst line", 32'(a_line), 32'd0);
    chk("pre-rst idx", 32'(a_idx), 32'd1);
    chk("pre-rst busy", 32'(a_busy), 32'd1);
    a_rst = 1'b1;
    #1;
    chk("async rst line", 32'(a_line), 32'd1);
    chk("async rst busy", 32'(a_busy), 32'd0);
    chk("async rst idx", 32'(a_idx), 32'd0);
    @(negedge clk_baud);
    a_rst = 1'b0; a_ready = 1'b1; a_abort = 1'b1;
    @(negedge clk_baud);
    a_ready = 1'b0; a_abort = 1'b0;
    check_a_packet("rerun", 32'hDE_AD_E0_E0);

    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
